// File: rtl/game_screen_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_screen_ctrl
//  Description : Frame-synchronous screen sequencer START -> COUNTDOWN -> GAME
//                -> END with layer enables, start-text blink, score overlay
//                placement and match result.
//  Revision    : 1.0  initial release
// ============================================================================
module game_screen_ctrl #(
  parameter int FRAME_LINE       = 768,
  parameter int BLINK_FRAMES     = 30,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int END_HOLD_FRAMES  = 120,
  parameter int GAME_MY_X        = 440,
  parameter int GAME_MY_Y        = 710,
  parameter int GAME_EN_X        = 520,
  parameter int GAME_EN_Y        = 710,
  parameter int END_MY_X         = 262,
  parameter int END_MY_Y         = 20,
  parameter int END_EN_X         = 507,
  parameter int END_EN_Y         = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        start_req,
  input  logic        game_over,
  input  logic [7:0]  my_score,
  input  logic [7:0]  enemy_score,
  output logic [1:0]  state,
  output logic        frame_tick,
  output logic        start_screen_en,
  output logic        game_en,
  output logic        end_screen_en,
  output logic        start_text_vis,
  output logic [10:0] my_score_xpos,
  output logic [10:0] my_score_ypos,
  output logic [10:0] enemy_score_xpos,
  output logic [10:0] enemy_score_ypos,
  output logic [1:0]  result
);

  typedef enum logic [1:0] {
    ST_START     = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_GAME      = 2'd2,
    ST_END       = 2'd3
  } state_t;

  localparam logic [10:0] c_frame_line = 11'(FRAME_LINE);
  localparam logic [7:0]  c_blink_last = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0]  c_cd_last    = 8'(COUNTDOWN_FRAMES - 1);
  localparam logic [7:0]  c_end_hold   = 8'(END_HOLD_FRAMES);
  localparam logic [10:0] c_game_my_x  = 11'(GAME_MY_X);
  localparam logic [10:0] c_game_my_y  = 11'(GAME_MY_Y);
  localparam logic [10:0] c_game_en_x  = 11'(GAME_EN_X);
  localparam logic [10:0] c_game_en_y  = 11'(GAME_EN_Y);
  localparam logic [10:0] c_end_my_x   = 11'(END_MY_X);
  localparam logic [10:0] c_end_my_y   = 11'(END_MY_Y);
  localparam logic [10:0] c_end_en_x   = 11'(END_EN_X);
  localparam logic [10:0] c_end_en_y   = 11'(END_EN_Y);

  state_t      r_state;
  logic        r_frame_tick;
  logic        r_start_d;
  logic        r_start_pend;
  logic        r_over_pend;
  logic [7:0]  r_frame_cnt;
  logic        r_vis;
  logic        r_start_en;
  logic        r_game_en;
  logic        r_end_en;
  logic [1:0]  r_result;
  logic [10:0] r_my_x;
  logic [10:0] r_my_y;
  logic [10:0] r_en_x;
  logic [10:0] r_en_y;

  state_t      w_nxt_state;
  logic        w_nxt_frame_tick;
  logic        w_start_rise;
  logic        w_nxt_start_pend;
  logic        w_nxt_over_pend;
  logic [7:0]  w_nxt_frame_cnt;
  logic        w_nxt_vis;
  logic        w_nxt_start_en;
  logic        w_nxt_game_en;
  logic        w_nxt_end_en;
  logic [1:0]  w_nxt_result;
  logic [10:0] w_nxt_my_x;
  logic [10:0] w_nxt_my_y;
  logic [10:0] w_nxt_en_x;
  logic [10:0] w_nxt_en_y;

  assign w_nxt_frame_tick = (hcount == 11'd0) && (vcount == c_frame_line);
  assign w_start_rise     = start_req & ~r_start_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_START;
      r_frame_tick <= 1'b0;
      r_start_d    <= 1'b0;
      r_start_pend <= 1'b0;
      r_over_pend  <= 1'b0;
      r_frame_cnt  <= 8'd0;
      r_vis        <= 1'b1;
      r_start_en   <= 1'b1;
      r_game_en    <= 1'b0;
      r_end_en     <= 1'b0;
      r_result     <= 2'd0;
      r_my_x       <= c_game_my_x;
      r_my_y       <= c_game_my_y;
      r_en_x       <= c_game_en_x;
      r_en_y       <= c_game_en_y;
    end else begin
      r_state      <= w_nxt_state;
      r_frame_tick <= w_nxt_frame_tick;
      r_start_d    <= start_req;
      r_start_pend <= w_nxt_start_pend;
      r_over_pend  <= w_nxt_over_pend;
      r_frame_cnt  <= w_nxt_frame_cnt;
      r_vis        <= w_nxt_vis;
      r_start_en   <= w_nxt_start_en;
      r_game_en    <= w_nxt_game_en;
      r_end_en     <= w_nxt_end_en;
      r_result     <= w_nxt_result;
      r_my_x       <= w_nxt_my_x;
      r_my_y       <= w_nxt_my_y;
      r_en_x       <= w_nxt_en_x;
      r_en_y       <= w_nxt_en_y;
    end
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_frame_cnt = r_frame_cnt;
    w_nxt_vis       = r_vis;
    w_nxt_result    = r_result;
    // Pend flags are consumed on every tick; a request landing on the tick itself survives to the next one.
    w_nxt_start_pend = r_frame_tick ? w_start_rise : (r_start_pend | w_start_rise);
    w_nxt_over_pend  = r_frame_tick ? game_over    : (r_over_pend  | game_over);

    if (r_frame_tick) begin
      case (r_state)
        ST_START: begin
          if (r_start_pend) begin
            w_nxt_state     = ST_COUNTDOWN;
            w_nxt_frame_cnt = 8'd0;
            w_nxt_vis       = 1'b1;
          end else if (r_frame_cnt == c_blink_last) begin
            w_nxt_frame_cnt = 8'd0;
            w_nxt_vis       = ~r_vis;
          end else begin
            w_nxt_frame_cnt = r_frame_cnt + 8'd1;
          end
        end
        ST_COUNTDOWN: begin
          if (r_frame_cnt == c_cd_last) begin
            w_nxt_state     = ST_GAME;
            w_nxt_frame_cnt = 8'd0;
          end else begin
            w_nxt_frame_cnt = r_frame_cnt + 8'd1;
          end
        end
        ST_GAME: begin
          if (r_over_pend) begin
            w_nxt_state     = ST_END;
            w_nxt_frame_cnt = 8'd0;
            if (my_score > enemy_score)      w_nxt_result = 2'd1;
            else if (my_score < enemy_score) w_nxt_result = 2'd2;
            else                             w_nxt_result = 2'd3;
          end
        end
        ST_END: begin
          if (r_frame_cnt < c_end_hold) begin
            w_nxt_frame_cnt = r_frame_cnt + 8'd1;
          end else if (r_start_pend) begin
            w_nxt_state     = ST_START;
            w_nxt_frame_cnt = 8'd0;
            w_nxt_vis       = 1'b1;
            w_nxt_result    = 2'd0;
          end
        end
        default: w_nxt_state = ST_START;
      endcase
    end

    w_nxt_start_en = (w_nxt_state == ST_START);
    w_nxt_game_en  = (w_nxt_state == ST_COUNTDOWN) || (w_nxt_state == ST_GAME);
    w_nxt_end_en   = (w_nxt_state == ST_END);
    w_nxt_my_x     = w_nxt_end_en ? c_end_my_x : c_game_my_x;
    w_nxt_my_y     = w_nxt_end_en ? c_end_my_y : c_game_my_y;
    w_nxt_en_x     = w_nxt_end_en ? c_end_en_x : c_game_en_x;
    w_nxt_en_y     = w_nxt_end_en ? c_end_en_y : c_game_en_y;
  end

  assign state            = r_state;
  assign frame_tick       = r_frame_tick;
  assign start_screen_en  = r_start_en;
  assign game_en          = r_game_en;
  assign end_screen_en    = r_end_en;
  assign start_text_vis   = r_vis;
  assign my_score_xpos    = r_my_x;
  assign my_score_ypos    = r_my_y;
  assign enemy_score_xpos = r_en_x;
  assign enemy_score_ypos = r_en_y;
  assign result           = r_result;

endmodule
`default_nettype wire
